ram_port_arbiter: RTL

// - Shares the single-port RAM (data_in/write_enb/read_enb/address/data_out) between NUM_REQ requesters.
// - Round-robin arbitration, per-requester req/gnt handshake, read data returned with rvalid pulse.
// - Sits between requester blocks and the RAM instance; owns every RAM control input.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/ram_port_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Width of a requester index; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner pick plus the last-winner pointer register.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               req_i,
  input  logic                       update_i,
  output logic                       any_c_o,
  output logic [idx_width(N)-1:0]    winner_c_o
);

  localparam int unsigned IW = idx_width(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] win_c;
  logic          any_c;
  int unsigned   cand;

  // First set request strictly after the pointer, wrapping around.
  always_comb begin
    any_c = 1'b0;
    win_c = '0;
    cand  = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(ptr_q) + i) % N;
      if (!any_c && req_i[IW'(cand)]) begin
        any_c = 1'b1;
        win_c = IW'(cand);
      end
    end
  end

  // Pointer remembers the last winner; reset value makes requester 0 highest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(N - 1);
    end else if (update_i && any_c) begin
      ptr_q <= win_c;
    end
  end

  assign any_c_o    = any_c;
  assign winner_c_o = win_c;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters with round-robin grants.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [NUM_REQ-1:0]                  rvalid,
  output logic [DATA_WIDTH-1:0]               rdata,
  output logic                                busy,
  output logic [DATA_WIDTH-1:0]               ram_data_in,
  output logic                                ram_write_enb,
  output logic                                ram_read_enb,
  output logic [ADDR_WIDTH-1:0]               ram_address,
  input  logic [DATA_WIDTH-1:0]               ram_data_out
);

  localparam int unsigned IW = idx_width(NUM_REQ);
  localparam int unsigned CW = $clog2(RD_LAT + 1);

  // Command fields are sized by this instance's parameters, so the type is local.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [IW-1:0]         idx;
  } cmd_t;

  state_e                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_re_q, ram_re_d;

  logic                  arb_any_c;
  logic [IW-1:0]         arb_win_c;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst_n      (reset),
    .req_i      (req),
    .update_i   (state_q == IDLE),
    .any_c_o    (arb_any_c),
    .winner_c_o (arb_win_c)
  );

  // State, latched command, latency counter and captured read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: arbitrate in IDLE only, count out the read latency.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any_c) begin
          cmd_d.we    = req_we[arb_win_c];
          cmd_d.addr  = req_addr[arb_win_c];
          cmd_d.wdata = req_wdata[arb_win_c];
          cmd_d.idx   = arb_win_c;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_q.we) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CW'(RD_LAT - 1);
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cnt_q == '0) begin
          rdata_d = ram_data_out;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    gnt_d      = '0;
    rvalid_d   = '0;
    busy_d     = (state_d != IDLE);
    ram_din_d  = '0;
    ram_addr_d = '0;
    ram_we_d   = 1'b0;
    ram_re_d   = 1'b0;
    if (state_d == ISSUE) begin
      gnt_d[cmd_d.idx] = 1'b1;
      ram_din_d        = cmd_d.wdata;
      ram_addr_d       = cmd_d.addr;
      ram_we_d         = cmd_d.we;
      ram_re_d         = !cmd_d.we;
    end
    if (state_d == RESP) begin
      rvalid_d[cmd_d.idx] = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q      <= '0;
      rvalid_q   <= '0;
      busy_q     <= 1'b0;
      ram_din_q  <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      busy_q     <= busy_d;
      ram_din_q  <= ram_din_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_re_q   <= ram_re_d;
    end
  end

  assign gnt           = gnt_q;
  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign busy          = busy_q;
  assign ram_data_in   = ram_din_q;
  assign ram_address   = ram_addr_q;
  assign ram_write_enb = ram_we_q;
  assign ram_read_enb  = ram_re_q;

endmodule
